// File: rtl/ntr_cmd_ctrl.sv
// ntr_cmd_ctrl
// Command controller between the NTR cartridge-bus receiver and the
// system-clock logic. The receiver's ready flag is synchronized into clk,
// each completed 64-bit command is captured into a small circular FIFO, and
// a dispatcher FSM drains the FIFO in capture order:
//   - LED_OPCODE   : led <= command bit 56, handled locally
//   - DUMMY_OPCODE : consumed, no effect
//   - anything else: offered downstream on cmd_valid/cmd_op/cmd_arg until cmd_ack
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ntr_ready       receiver command-complete flag (asynchronous to clk)
//   ntr_command     receiver command, opcode in [7:0], stable while ntr_ready high
//   led             LED state
//   cmd_valid       forwarded command available
//   cmd_op/cmd_arg  forwarded opcode / argument (ntr_command[63:8])
//   cmd_ack         downstream accepts the forwarded command
//   overflow        sticky: a capture was dropped on a full FIFO
//   drop_count      dropped-capture count
//
// Build option
//   NTR_CMD_DROPCNT_EN : when defined, drop_count counts dropped captures and
//                        saturates at 8'hFF; otherwise it is tied to 8'h00.
module ntr_cmd_ctrl #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  LED_OPCODE   = 8'hFF,
  parameter logic [7:0]  DUMMY_OPCODE = 8'h9F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ntr_ready,
  input  logic [63:0] ntr_command,
  output logic        led,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [55:0] cmd_arg,
  input  logic        cmd_ack,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_EXEC, ST_HANDOFF} state_t;

  // ---------------------------------------------------------------------------
  // Ready synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic       s1_q, s2_q, s3_q;
  logic       armed_q, armed_d;
  logic [1:0] live_q, live_d;
  logic       capture;

  // live_q fills with ones over the first two edges after reset, marking when
  // s2 holds a real sample of ntr_ready rather than its reset value. Arming
  // only on a real low sample means a ready that was already high across
  // reset release is never taken as a new command.
  always_comb begin
    live_d  = {live_q[0], 1'b1};
    armed_d = armed_q | (live_q[1] & ~s2_q);
    capture = s2_q & ~s3_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      armed_q <= 1'b0;
      live_q  <= 2'b00;
    end else begin
      s1_q    <= ntr_ready;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      armed_q <= armed_d;
      live_q  <= live_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, push, pop, drop;
  logic [63:0]   head;

  // Fullness uses the count before this cycle's pop, so a pop never frees a
  // slot for a capture landing in the same cycle.
  always_comb begin
    full       = (count_q == CW'(FIFO_DEPTH));
    push       = capture & ~full;
    drop       = capture & full;
    pop        = (state_q == ST_POP);
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
    head       = mem_q[rptr_q];
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ntr_command;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatcher FSM
  // ---------------------------------------------------------------------------
  logic [7:0]  op_q;
  logic [55:0] arg_q;
  logic        led_q, cmd_valid_q;

  // op_q/arg_q only reload in POP, which cannot happen while in HANDOFF, so
  // they double as the stable forwarded opcode/argument.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      arg_q       <= '0;
      led_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (count_q != '0) state_q <= ST_POP;
        ST_POP: begin
          op_q    <= head[7:0];
          arg_q   <= head[63:8];
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_q == LED_OPCODE) begin
            led_q   <= arg_q[48];
            state_q <= ST_IDLE;
          end else if (op_q == DUMMY_OPCODE) begin
            state_q <= ST_IDLE;
          end else begin
            cmd_valid_q <= 1'b1;
            state_q     <= ST_HANDOFF;
          end
        end
        ST_HANDOFF: if (cmd_ack) begin
          cmd_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign led       = led_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = op_q;
  assign cmd_arg   = arg_q;
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------------
  // Optional drop counter
  // ---------------------------------------------------------------------------
`ifdef NTR_CMD_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= 8'h00;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_ntr_cmd_ctrl.sv
// Scoreboard bench for ntr_cmd_ctrl. Stimulus pushes the expected visible
// effects (LED transitions and forwarded commands, in capture order) into a
// queue; an independent monitor pops and compares whenever the DUT shows an
// LED change or a new cmd_valid offer, and also checks handshake holding.
module tb_ntr_cmd_ctrl;

  logic        clk, rst, ntr_ready, cmd_ack;
  logic [63:0] ntr_command;
  logic        led, cmd_valid, overflow;
  logic [7:0]  cmd_op, drop_count;
  logic [55:0] cmd_arg;

  logic ack_force, ack_rnd, ack_en;
  assign cmd_ack = ack_force | ack_rnd;

`ifdef NTR_CMD_DROPCNT_EN
  localparam logic [7:0] EXP_DROP1 = 8'd1;
`else
  localparam logic [7:0] EXP_DROP1 = 8'd0;
`endif

  ntr_cmd_ctrl dut (
    .clk(clk), .rst(rst), .ntr_ready(ntr_ready), .ntr_command(ntr_command),
    .led(led), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ack(cmd_ack), .overflow(overflow), .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_led;
    bit          led;
    logic [7:0]  op;
    logic [55:0] arg;
  } exp_t;

  exp_t exp_q[$];
  bit   model_led;
  int   n_cmp, n_fail;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: LED commands change the LED (visible only on a change),
  // dummies vanish, everything else is forwarded unchanged.
  function automatic void model_cmd(input logic [63:0] c);
    exp_t e;
    e.is_led = 1'b0; e.led = 1'b0; e.op = c[7:0]; e.arg = c[63:8];
    if (c[7:0] == 8'hFF) begin
      if (c[56] != model_led) begin
        model_led = c[56];
        e.is_led  = 1'b1;
        e.led     = c[56];
        exp_q.push_back(e);
      end
    end else if (c[7:0] != 8'h9F) begin
      exp_q.push_back(e);
    end
  endfunction

  task automatic send(input logic [63:0] c, input int hi, input int lo);
    @(negedge clk);
    ntr_command = c;
    ntr_ready   = 1'b1;
    repeat (hi) @(negedge clk);
    ntr_ready = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int k = 0;
    while (cmd_valid !== 1'b1 && k < lim) begin
      @(posedge clk); #1;
      k++;
    end
    check(nm, 64'(cmd_valid), 64'd1);
  endtask

  task automatic drain(input string nm, input int lim);
    int k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(nm, 64'(exp_q.size()), 64'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_led"},   64'(led),        64'd0);
    check({nm, "_valid"}, 64'(cmd_valid),  64'd0);
    check({nm, "_op"},    64'(cmd_op),     64'd0);
    check({nm, "_arg"},   64'(cmd_arg),    64'd0);
    check({nm, "_ovf"},   64'(overflow),   64'd0);
    check({nm, "_drop"},  64'(drop_count), 64'd0);
  endtask

  function automatic logic [63:0] rnd_cmd(input logic [7:0] op);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {r[63:8], op};
  endfunction

  // Random acknowledges, including while nothing is offered.
  initial begin
    ack_rnd = 1'b0;
    forever begin
      @(negedge clk);
      ack_rnd = ack_en && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor
  initial begin
    bit          prev_valid, prev_led, ack_s, rst_s;
    logic [7:0]  prev_op;
    logic [55:0] prev_arg;
    exp_t        e;
    prev_valid = 0; prev_led = 0; prev_op = '0; prev_arg = '0;
    forever begin
      @(posedge clk);
      ack_s = cmd_ack;
      rst_s = rst;
      #1;
      if (rst_s) begin
        prev_valid = 0;
        prev_led   = 0;
      end else begin
        if (led !== prev_led) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL led_event: unexpected led change to %0b", led);
          end else begin
            e = exp_q.pop_front();
            check("led_kind", 64'(e.is_led), 64'd1);
            check("led_val",  64'(led),      64'(e.led));
          end
        end
        if (prev_valid && ack_s) begin
          check("ack_drop", 64'(cmd_valid), 64'd0);
        end else if (cmd_valid && prev_valid) begin
          check("hold", {cmd_op, cmd_arg}, {prev_op, prev_arg});
        end
        if (cmd_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL fwd_event: unexpected offer op %h arg %h", cmd_op, cmd_arg);
          end else begin
            e = exp_q.pop_front();
            check("fwd_kind", 64'(e.is_led), 64'd0);
            check("fwd_cmd",  {cmd_op, cmd_arg}, {e.op, e.arg});
          end
        end
        prev_valid = cmd_valid;
        prev_led   = led;
        prev_op    = cmd_op;
        prev_arg   = cmd_arg;
      end
    end
  end

  // Stimulus
  initial begin
    logic [63:0] c;
    n_cmp = 0; n_fail = 0; model_led = 0;
    rst = 1'b1; ntr_ready = 1'b0; ntr_command = '0;
    ack_force = 1'b0; ack_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // LED on, with edge-accurate latency, then LED off
    c = 64'h0100_0000_0000_00FF;
    @(negedge clk);
    ntr_command = c; ntr_ready = 1'b1; model_cmd(c);
    repeat (5) @(posedge clk);
    #1 check("t1_led_e4", 64'(led), 64'd0);
    @(posedge clk);
    #1 check("t1_led_e5", 64'(led), 64'd1);
    check("t1_novalid", 64'(cmd_valid), 64'd0);
    @(negedge clk); ntr_ready = 1'b0;
    repeat (3) @(negedge clk);
    c = 64'h0000_0000_0000_00FF; model_cmd(c);
    send(c, 2, 10);
    check("t1_led_off", 64'(led), 64'd0);

    // Forwarded command held against a stalled ack, then one ack pulse
    c = 64'h1122_3344_5566_77B7; model_cmd(c);
    send(c, 2, 2);
    wait_valid("t2_valid", 20);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t2_valid_hold", 64'(cmd_valid), 64'd1);
      check("t2_op",  64'(cmd_op),  64'hB7);
      check("t2_arg", 64'(cmd_arg), 64'h0011_2233_4455_6677);
    end
    @(negedge clk); ack_force = 1'b1;
    @(posedge clk); #1 check("t2_ack", 64'(cmd_valid), 64'd0);
    @(negedge clk); ack_force = 1'b0;
    repeat (4) @(negedge clk);

    // Dummy opcode: no visible effect
    c = 64'h0100_0000_0000_009F; model_cmd(c);
    send(c, 2, 12);
    check("t4_led", 64'(led), 64'(model_led));
    check("t4_valid", 64'(cmd_valid), 64'd0);

    // Randomized mix with random acknowledges
    ack_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       c = rnd_cmd(8'hFF);
        1:       c = rnd_cmd(8'h9F);
        default: begin
          c = rnd_cmd(8'($urandom_range(0, 8'h9E)));
        end
      endcase
      model_cmd(c);
      send(c, $urandom_range(2, 4), $urandom_range(4, 10));
    end
    drain("rand_drain", 400);
    check("rand_ovf", 64'(overflow), 64'd0);

    // Overflow: one command stalled in handoff, four fill the FIFO, sixth dropped
    ack_en = 1'b0;
    c = rnd_cmd(8'h10); model_cmd(c);
    send(c, 2, 2);
    wait_valid("t3_valid", 20);
    for (int i = 1; i < 5; i++) begin
      c = rnd_cmd(8'(8'h10 + i)); model_cmd(c);
      send(c, 2, 2);
    end
    repeat (3) @(negedge clk);
    check("t3_ovf_pre", 64'(overflow), 64'd0);
    send(rnd_cmd(8'h15), 2, 4);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_drop", 64'(drop_count), 64'(EXP_DROP1));
    ack_en = 1'b1;
    drain("t3_drain", 200);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Reset during handoff with two queued
    ack_en = 1'b0;
    c = rnd_cmd(8'h21); model_cmd(c);
    send(c, 2, 2);
    wait_valid("t6_valid", 20);
    send(rnd_cmd(8'h22), 2, 2);
    send(rnd_cmd(8'h23), 2, 3);
    @(negedge clk);
    rst = 1'b1; exp_q.delete(); model_led = 0;
    @(posedge clk); #1 check_zero("t6_rst");
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    ack_en = 1'b1;
    c = rnd_cmd(8'h24); model_cmd(c);
    send(c, 2, 4);
    drain("t6_drain", 100);

    // Ready held high across reset release: ignored until it falls and rises
    @(negedge clk);
    ntr_command = rnd_cmd(8'h33); ntr_ready = 1'b1; rst = 1'b1;
    exp_q.delete(); model_led = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_nocap", 64'(cmd_valid), 64'd0);
    ntr_ready = 1'b0;
    repeat (2) @(negedge clk);
    c = rnd_cmd(8'h44); model_cmd(c);
    ntr_command = c; ntr_ready = 1'b1;
    repeat (4) @(negedge clk);
    ntr_ready = 1'b0;
    drain("t5_drain", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ntr_cmd_ctrl.md
# ntr_cmd_ctrl

Command controller between the NTR cartridge-bus receiver and the system-clock logic. It synchronizes the receiver's `ready` flag into the `clk` domain and captures each completed 64-bit command into a small FIFO. A dispatcher FSM then executes LED commands locally, discards dummy commands, and hands every other command to downstream logic over a valid/ack handshake. It replaces ad-hoc command polling in the top level.

## Interface
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, 2–16
- `LED_OPCODE`, 8'hFF, opcode executed locally as an LED write
- `DUMMY_OPCODE`, 8'h9F, opcode consumed and discarded
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `ntr_ready`  in  1  receiver command-complete flag; asynchronous to `clk`
- `ntr_command`  in  64  receiver command; stable while `ntr_ready` is high; opcode in [7:0]
- `led`  out  1  LED state
- `cmd_valid`  out  1  forwarded command available
- `cmd_op`  out  8  forwarded opcode
- `cmd_arg`  out  56  forwarded argument = `ntr_command[63:8]`
- `cmd_ack`  in  1  downstream accepts the forwarded command
- `overflow`  out  1  sticky flag: a command was dropped on a full FIFO
- `drop_count`  out  8  number of dropped commands

## Operation
- **Reset.** All outputs are 0. FIFO is empty. FSM is in IDLE. The synchronizer, edge register and `armed` are 0.
- **Synchronizer.** `ntr_ready` passes through two flops (`s1`, `s2`) and an edge register `s3`.
  - `armed` sets the first cycle `s2` is 0 after reset.
  - A capture fires when `s2 & ~s3 & armed`. A `ready` already high when reset is released is therefore never captured.
- **Capture.** On a capture, `ntr_command` is written into the FIFO tail.
  - If the FIFO is full, the write is dropped and `overflow` is set until `rst`.
  - Fullness is judged on the pre-cycle count. A pop in the same cycle does not free a slot for that write.
- **FIFO.** Circular buffer with pointers of width log2(FIFO_DEPTH).
  - Pointers wrap naturally.
  - Count is held in a separate register of width log2(FIFO_DEPTH)+1.
  - Simultaneous push and pop leaves the count unchanged.
- **Dispatcher FSM (IDLE, POP, EXEC, HANDOFF).**
  - IDLE → POP when the FIFO is non-empty.
  - POP: load the head into the `op`/`arg` registers and advance the read pointer. → EXEC.
  - EXEC, `op == LED_OPCODE`: `led <= arg[48]` (original bit 56). → IDLE.
  - EXEC, `op == DUMMY_OPCODE`: no effect. → IDLE.
  - EXEC, any other opcode: assert `cmd_valid`. → HANDOFF.
  - HANDOFF: hold `cmd_valid`, `cmd_op` and `cmd_arg` stable until `cmd_ack`. On the cycle `cmd_ack` is high, deassert `cmd_valid` the next cycle. → IDLE.
  - `cmd_ack` while `cmd_valid` is low is ignored.
- **Ordering.** Commands are dispatched strictly in capture order. The FIFO keeps capturing while in HANDOFF.

## Timing
- Let E0 be the first `clk` edge at which `s1` samples `ntr_ready` high.
  - `s2` rises at E1.
  - FIFO write at E2.
  - IDLE→POP at E3; POP→EXEC at E4.
  - `led` or `cmd_valid` updates at E5.
- Best-case latency from `ready` to effect: 6 edges.
- Each command needs at least 3 cycles of dispatch, plus the handshake wait for forwarded commands.
- Back-to-back dispatch: the next POP starts one cycle after returning to IDLE.
- The `ntr_ready` low and high phases must each last at least 2 `clk` cycles. Shorter pulses may be missed; this is not detected.
- `rst` asserted mid-handoff drops `cmd_valid` at the next edge. FIFO contents are discarded.

## Configuration
- **`NTR_CMD_DROPCNT_EN` defined:** `drop_count` increments on every dropped capture and saturates at 8'hFF. It is cleared by `rst`.
- **`NTR_CMD_DROPCNT_EN` undefined:** the counter is not built and `drop_count` is tied to 8'h00. `overflow` still operates.

## Test plan
- Reset, then one `ready` pulse with command 64'h0100_0000_0000_00FF → `led` = 1 at E5; `cmd_valid` stays 0. A second pulse with 64'h0000_0000_0000_00FF → `led` = 0.
- Command 64'h1122_3344_5566_77B7 with `cmd_ack` held low for 10 cycles → `cmd_valid` = 1 with `cmd_op` = 8'hB7 and `cmd_arg` = 56'h11223344556677, stable throughout. Pulse `cmd_ack` → `cmd_valid` = 0 next cycle.
- 6 captures during a stalled HANDOFF with FIFO_DEPTH=4 → the first command is held in HANDOFF while four further captures fill the FIFO (five accepted in total); the sixth is dropped, `overflow` = 1 and `drop_count` = 1 (0 without the macro). After ack, the remaining four dispatch in order.
- Opcode 8'h9F → no `led` change, no `cmd_valid`, FSM back in IDLE after 3 dispatch cycles.
- `ntr_ready` held high through `rst` release → no capture. Drop it low for 2 cycles, then raise it → exactly one capture.
- `rst` asserted during HANDOFF with 2 entries queued → all outputs 0 next cycle and FIFO empty; the next capture dispatches normally.
